// File: rtl/ram_arb_pkg.sv
// Shared types for the main-RAM arbiter: access FSM states, master IDs and
// the fixed length of one RAM access.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE
   } state_t;

   typedef enum logic [1:0] {
      VID,
      CPU,
      EXT
   } master_t;

   localparam int ACCESS_CYCLES = 2;

endpackage

// File: rtl/ram_arb_pick.sv
// Priority pick between the three RAM masters plus the counter that lets a
// starved ext request overtake the CPU (never the video fetch).
module ram_arb_pick
   import ram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    vid_req_i,
   input  logic    cpu_req_i,
   input  logic    ext_req_i,
   input  logic    ext_pend_i,
   input  logic    gnt_i,
   output logic    pick_vld_o,
   output master_t pick_id_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             starved;

   assign starved = (cnt_q == CNT_MAX);

   always_comb begin
      pick_vld_o = vid_req_i | cpu_req_i | ext_req_i;
      pick_id_o  = EXT;
      if (vid_req_i) begin
         pick_id_o = VID;
      end else if (cpu_req_i && !(ext_req_i && starved)) begin
         pick_id_o = CPU;
      end
   end

   // Counts CPU wins only while ext is actually waiting; any ext grant or
   // withdrawal of the ext request resets the tally.
   always_comb begin
      cnt_d = cnt_q;
      if (!ext_pend_i) begin
         cnt_d = '0;
      end else if (gnt_i && (pick_id_o == EXT)) begin
         cnt_d = '0;
      end else if (gnt_i && (pick_id_o == CPU) && !starved) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Three-master arbiter (video, Z80, STM32) in front of one asynchronous SRAM;
// every access is a SETUP clock followed by a STROBE clock.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK_14MHZ,
   input  logic              RESET,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_done,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_wait,
   input  logic              ext_req,
   input  logic              ext_wr,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_cs_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic              ram_dq_oe
);

   state_t            state_q, state_d;
   master_t           id_q, id_d;
   master_t           pick_id;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              vid_done_q, vid_done_d;
   logic              cpu_done_q, cpu_done_d;
   logic              ext_done_q, ext_done_d;
   logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              vid_live, cpu_live, ext_live;
   logic              arb_en, pick_vld, gnt, acc, strobe;

   // A master's request level in its own done cycle is the stale one it held
   // for the access just finished, so it is not allowed to win again.
   assign vid_live = vid_req & ~vid_done_q;
   assign cpu_live = cpu_req & ~cpu_done_q;
   assign ext_live = ext_req & ~ext_done_q;

   assign arb_en = (state_q == IDLE) || (state_q == STROBE);
   assign gnt    = arb_en & pick_vld;
   assign acc    = (state_q != IDLE);
   assign strobe = (state_q == STROBE);

   ram_arb_pick #(
      .STARVE_MAX(STARVE_MAX)
   ) u_pick (
      .clk_i     (CLK_14MHZ),
      .rst_i     (RESET),
      .vid_req_i (vid_live),
      .cpu_req_i (cpu_live),
      .ext_req_i (ext_live),
      .ext_pend_i(ext_req),
      .gnt_i     (gnt),
      .pick_vld_o(pick_vld),
      .pick_id_o (pick_id)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         SETUP:   state_d = STROBE;
         default: state_d = IDLE;
      endcase
      if (gnt) begin
         state_d = SETUP;
         id_d    = pick_id;
         case (pick_id)
            VID: begin
               addr_d  = vid_addr;
               wr_d    = 1'b0;
               wdata_d = '0;
            end
            CPU: begin
               addr_d  = cpu_addr;
               wr_d    = cpu_wr;
               wdata_d = cpu_wdata;
            end
            default: begin
               addr_d  = ext_addr;
               wr_d    = ext_wr;
               wdata_d = ext_wdata;
            end
         endcase
      end
   end

   always_comb begin
      vid_done_d  = strobe && (id_q == VID);
      cpu_done_d  = strobe && (id_q == CPU);
      ext_done_d  = strobe && (id_q == EXT);
      vid_rdata_d = vid_rdata_q;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      if (strobe && !wr_q) begin
         case (id_q)
            VID:     vid_rdata_d = ram_rdata;
            CPU:     cpu_rdata_d = ram_rdata;
            default: ext_rdata_d = ram_rdata;
         endcase
      end
   end

   always_ff @(posedge CLK_14MHZ or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         id_q        <= VID;
         wr_q        <= 1'b0;
         vid_done_q  <= 1'b0;
         cpu_done_q  <= 1'b0;
         ext_done_q  <= 1'b0;
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         wr_q        <= wr_d;
         vid_done_q  <= vid_done_d;
         cpu_done_q  <= cpu_done_d;
         ext_done_q  <= ext_done_d;
         vid_rdata_q <= vid_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   // Address/data only matter while the strobes are active, so no reset.
   always_ff @(posedge CLK_14MHZ) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_cs_n  = ~acc;
   assign ram_oe_n  = ~(acc & ~wr_q);
   assign ram_we_n  = ~(strobe & wr_q);
   assign ram_dq_oe = acc & wr_q;

   assign vid_rdata = vid_rdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ext_rdata = ext_rdata_q;
   assign vid_done  = vid_done_q;
   assign cpu_done  = cpu_done_q;
   assign ext_done  = ext_done_q;
   assign cpu_wait  = ~RESET & cpu_req & ~((acc & (id_q == CPU)) | cpu_done_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 256-byte behavioural SRAM whose
// unwritten contents are addr ^ 8'h3C.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic        CLK_14MHZ;
   logic        RESET;
   logic        vid_req;
   logic [18:0] vid_addr;
   logic [7:0]  vid_rdata;
   logic        vid_done;
   logic        cpu_req, cpu_wr;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_done, cpu_wait;
   logic        ext_req, ext_wr;
   logic [18:0] ext_addr;
   logic [7:0]  ext_wdata, ext_rdata;
   logic        ext_done;
   logic [18:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        ram_cs_n, ram_oe_n, ram_we_n, ram_dq_oe;

   logic [7:0]  mem [0:255];
   logic        mem_clr;
   int          checks;
   int          failures;

   ram_arbiter dut (
      .CLK_14MHZ(CLK_14MHZ), .RESET(RESET),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_done(vid_done),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_wait(cpu_wait),
      .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_done(ext_done),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_dq_oe(ram_dq_oe)
   );

   initial CLK_14MHZ = 1'b0;
   always #5 CLK_14MHZ = ~CLK_14MHZ;

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'h3C;
   endfunction

   always @(posedge CLK_14MHZ) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      end else if (!ram_cs_n && !ram_we_n) begin
         mem[ram_addr[7:0]] <= ram_wdata;
      end
   end
   assign ram_rdata = mem[ram_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK_14MHZ);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      RESET = 1'b1;
      mem_clr = 1'b1;
      vid_req = 0; vid_addr = '0;
      cpu_req = 1; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_wr = 0; ext_addr = '0; ext_wdata = '0;
      cyc(3);
      check("rst_cs_n", ram_cs_n, 1);
      check("rst_oe_n", ram_oe_n, 1);
      check("rst_we_n", ram_we_n, 1);
      check("rst_dq_oe", ram_dq_oe, 0);
      check("rst_dones", {vid_done, cpu_done, ext_done}, 0);
      check("rst_cpu_wait", cpu_wait, 0);
      check("rst_rdata", {vid_rdata, cpu_rdata, ext_rdata}, 0);
      cpu_req = 0;
      RESET = 0;
      mem_clr = 0;
      cyc(1);

      // single ext read on an idle bus
      ext_req = 1; ext_addr = 19'h00012;
      cyc(1);
      check("xr_setup_cs", ram_cs_n, 0);
      check("xr_addr", ram_addr, 19'h00012);
      check("xr_we_n", ram_we_n, 1);
      ext_req = 0;
      repeat (ACCESS_CYCLES - 1) begin
         check("xr_oe_n", ram_oe_n, 0);
         check("xr_done_early", ext_done, 0);
         cyc(1);
      end
      check("xr_oe_n_strobe", ram_oe_n, 0);
      cyc(1);
      check("xr_done", ext_done, 1);
      check("xr_rdata", ext_rdata, 8'h2E);
      check("xr_idle_cs", ram_cs_n, 1);
      check("xr_idle_oe", ram_oe_n, 1);
      cyc(1);
      check("xr_done_pulse", ext_done, 0);

      // all three request in the same cycle
      vid_req = 1; vid_addr = 19'h10;
      cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h20;
      ext_req = 1; ext_wr = 0; ext_addr = 19'h30;
      cyc(1);
      check("all_first_vid", ram_addr, 19'h10);
      check("all_cpu_wait", cpu_wait, 1);
      vid_req = 0;
      cyc(2);
      check("all_vid_done", vid_done, 1);
      check("all_vid_rdata", vid_rdata, 8'h2C);
      check("all_second_cpu", ram_addr, 19'h20);
      check("all_cpu_wait_acc", cpu_wait, 0);
      cpu_req = 0;
      cyc(2);
      check("all_vid_done_pulse", vid_done, 0);
      check("all_cpu_done", cpu_done, 1);
      check("all_cpu_rdata", cpu_rdata, 8'h1C);
      check("all_third_ext", ram_addr, 19'h30);
      ext_req = 0;
      cyc(2);
      check("all_ext_done", ext_done, 1);
      check("all_ext_rdata", ext_rdata, 8'h0C);
      check("all_idle_cs", ram_cs_n, 1);
      cyc(1);

      // cpu write then read-back of the same address
      cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h7C000; cpu_wdata = 8'hA5;
      #1;
      check("wr_wait_idle", cpu_wait, 1);
      cyc(1);
      check("wr_setup_we_n", ram_we_n, 1);
      check("wr_setup_dq_oe", ram_dq_oe, 1);
      check("wr_setup_oe_n", ram_oe_n, 1);
      check("wr_wdata", ram_wdata, 8'hA5);
      cpu_req = 0;
      cyc(1);
      check("wr_strobe_we_n", ram_we_n, 0);
      check("wr_strobe_dq_oe", ram_dq_oe, 1);
      cyc(1);
      check("wr_done", cpu_done, 1);
      check("wr_done_we_n", ram_we_n, 1);
      cpu_req = 1; cpu_wr = 0;
      #1;
      check("rd_wait_in_done", cpu_wait, 0);
      cyc(1);
      check("rd_no_regrant_cs", ram_cs_n, 1);
      check("rd_wait_pending", cpu_wait, 1);
      cyc(1);
      check("rd_setup_oe_n", ram_oe_n, 0);
      check("rd_setup_dq_oe", ram_dq_oe, 0);
      cpu_req = 0;
      cyc(2);
      check("rd_done", cpu_done, 1);
      check("rd_rdata", cpu_rdata, 8'hA5);
      cyc(1);

      // cpu streaming while ext waits: ext gets in after 4 cpu grants
      cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h40;
      ext_req = 1; ext_wr = 0; ext_addr = 19'h50;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         check("stv_cpu_grant", ram_addr, 19'h40);
         cyc(1);
      end
      cyc(1);
      check("stv_ext_grant", ram_addr, 19'h50);
      ext_req = 0;
      cyc(2);
      check("stv_cpu_after", ram_addr, 19'h40);
      ext_req = 1;
      for (int k = 0; k < 4; k++) begin
         cyc(2);
         check("stv_cpu_regrant", ram_addr, 19'h40);
      end
      cyc(2);
      check("stv_ext_again", ram_addr, 19'h50);
      cpu_req = 0; ext_req = 0;
      cyc(2);
      check("stv_ext_done", ext_done, 1);
      cyc(1);

      // video streaming always beats a waiting ext
      vid_req = 1; vid_addr = 19'h60;
      ext_req = 1; ext_wr = 0; ext_addr = 19'h70;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         check("vx_vid_grant", ram_addr, 19'h60);
         check("vx_no_ext_done", ext_done, 0);
         if (k == 5) vid_req = 0;
         cyc(1);
      end
      cyc(1);
      check("vx_ext_grant", ram_addr, 19'h70);
      ext_req = 0;
      cyc(2);
      check("vx_ext_done", ext_done, 1);
      check("vx_ext_rdata", ext_rdata, 8'h4C);
      cyc(1);

      // reset during the STROBE of an ext write
      ext_req = 1; ext_wr = 1; ext_addr = 19'h80; ext_wdata = 8'h5A;
      cyc(1);
      ext_req = 0;
      cyc(1);
      check("rw_strobe_we_n", ram_we_n, 0);
      #2;
      RESET = 1;
      #1;
      check("rw_async_we_n", ram_we_n, 1);
      check("rw_async_cs_n", ram_cs_n, 1);
      check("rw_async_dq_oe", ram_dq_oe, 0);
      cyc(1);
      check("rw_no_done", ext_done, 0);
      check("rw_rdata_clr", {ext_rdata, cpu_rdata}, 0);
      cyc(1);
      check("rw_no_done_late", ext_done, 0);
      RESET = 0;
      ext_req = 1; ext_wr = 0; ext_addr = 19'h80;
      cyc(1);
      check("rw_first_grant", ram_cs_n, 0);
      check("rw_first_addr", ram_addr, 19'h80);
      ext_req = 0;
      cyc(2);
      check("rw_readback_done", ext_done, 1);
      check("rw_not_written", ext_rdata, 8'hBC);
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
